// File: rtl/snake_pkg.sv
// Shared types and constants for the snake move scheduler.
package snake_pkg;

    localparam int unsigned COORD_W    = 6;
    localparam int unsigned GRID_W_DEF = 40;
    localparam int unsigned GRID_H_DEF = 30;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StCompute,
        StCheck,
        StCommit,
        StDead
    } state_t;

    // Encoding pairs opposite directions on bit 0.
    function automatic dir_t dir_opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_tick_div.sv
// Move-rate divider: emits a 1-cycle tick every period_i enabled cycles.
module snake_tick_div #(
    parameter int unsigned CNT_W = 3
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           enable_i,
    input  logic [CNT_W:0] period_i,
    output logic           tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             restart;

    assign tick_o  = enable_i && (cnt_q == last_q);
    assign restart = !enable_i || tick_o;

    // Period is captured only when the count restarts, so a mid-count speed change
    // takes effect on the next interval.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        last_d = last_q;
        if (restart) begin
            cnt_d  = '0;
            last_d = CNT_W'(period_i - 1'b1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/snake_move_scheduler.sv
// Snake move scheduler: paces head moves, arbitrates direction and screens each
// candidate head cell against the walls and the body before committing it.
module snake_move_scheduler
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = GRID_W_DEF,
    parameter int unsigned GRID_H    = GRID_H_DEF,
    parameter int unsigned TICK_BASE = 2_500_000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               playing_i,
    input  logic               btn_up_i,
    input  logic               btn_down_i,
    input  logic               btn_left_i,
    input  logic               btn_right_i,
    input  logic [1:0]         speed_sel_i,
    input  logic [COORD_W-1:0] food_x_i,
    input  logic [COORD_W-1:0] food_y_i,
    output logic               check_req_o,
    output logic [COORD_W-1:0] check_x_o,
    output logic [COORD_W-1:0] check_y_o,
    input  logic               check_ack_i,
    input  logic               body_hit_i,
    output logic               shift_o,
    output logic               grow_o,
    output logic [COORD_W-1:0] head_x_o,
    output logic [COORD_W-1:0] head_y_o,
    output logic [1:0]         dir_o,
    output logic               collision_o
);

    localparam int unsigned CNT_W = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
    localparam logic [COORD_W-1:0] CTR_X = COORD_W'(GRID_W / 2);
    localparam logic [COORD_W-1:0] CTR_Y = COORD_W'(GRID_H / 2);
    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(GRID_H - 1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
    logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    dir_t               dir_q, dir_d, pending_q, pending_d, cand_dir_q, cand_dir_d;
    logic               check_req_q, check_req_d;
    logic               shift_q, shift_d, grow_q, grow_d, collision_q, collision_d;

    logic               tick, tick_en, oob, req_vld;
    dir_t               req_dir;
    logic [31:0]        period_raw;
    logic [CNT_W:0]     period;

    // Fast speeds on a small base would shift the period to zero; hold it at one cycle.
    always_comb begin
        period_raw = TICK_BASE >> speed_sel_i;
        period     = (period_raw == 32'd0) ? (CNT_W+1)'(1) : (CNT_W+1)'(period_raw);
    end

    assign tick_en = (state_q == StWaitTick) && playing_i;

    snake_tick_div #(
        .CNT_W(CNT_W)
    ) u_tick_div (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enable_i(tick_en),
        .period_i(period),
        .tick_o  (tick)
    );

    always_comb begin
        state_d     = state_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        dir_d       = dir_q;
        pending_d   = pending_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        cand_dir_d  = cand_dir_q;
        check_req_d = 1'b0;
        shift_d     = 1'b0;
        grow_d      = 1'b0;
        collision_d = 1'b0;
        oob         = 1'b0;
        req_vld     = 1'b1;
        req_dir     = RIGHT;

        if (btn_up_i)         req_dir = UP;
        else if (btn_down_i)  req_dir = DOWN;
        else if (btn_left_i)  req_dir = LEFT;
        else if (btn_right_i) req_dir = RIGHT;
        else                  req_vld = 1'b0;

        if (state_q != StIdle && req_vld && req_dir != dir_opposite(dir_q)) begin
            pending_d = req_dir;
        end

        unique case (state_q)
            StIdle: if (playing_i) state_d = StWaitTick;
            StWaitTick: if (tick) state_d = StCompute;
            StCompute: begin
                cand_dir_d = pending_q;
                cand_x_d   = head_x_q;
                cand_y_d   = head_y_q;
                unique case (pending_q)
                    UP: begin
                        oob      = (head_y_q == '0);
                        cand_y_d = head_y_q - 1'b1;
                    end
                    DOWN: begin
                        oob      = (head_y_q == MAX_Y);
                        cand_y_d = head_y_q + 1'b1;
                    end
                    LEFT: begin
                        oob      = (head_x_q == '0);
                        cand_x_d = head_x_q - 1'b1;
                    end
                    RIGHT: begin
                        oob      = (head_x_q == MAX_X);
                        cand_x_d = head_x_q + 1'b1;
                    end
                endcase
                if (oob) begin
                    state_d     = StDead;
                    collision_d = 1'b1;
                end else begin
                    state_d     = StCheck;
                    check_req_d = 1'b1;
                end
            end
            StCheck: begin
                check_req_d = 1'b1;
                if (check_ack_i) begin
                    check_req_d = 1'b0;
                    if (body_hit_i) begin
                        state_d     = StDead;
                        collision_d = 1'b1;
                    end else begin
                        state_d  = StCommit;
                        head_x_d = cand_x_q;
                        head_y_d = cand_y_q;
                        dir_d    = cand_dir_q;
                        grow_d   = (cand_x_q == food_x_i) && (cand_y_q == food_y_i);
                        shift_d  = !grow_d;
                    end
                end
            end
            StCommit: state_d = StWaitTick;
            StDead: if (!playing_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Leaving play aborts whatever step is in flight without side effects.
        if (!playing_i) begin
            state_d     = StIdle;
            check_req_d = 1'b0;
            shift_d     = 1'b0;
            grow_d      = 1'b0;
            collision_d = 1'b0;
        end

        if (state_d == StIdle) begin
            head_x_d  = CTR_X;
            head_y_d  = CTR_Y;
            dir_d     = RIGHT;
            pending_d = RIGHT;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            head_x_q    <= CTR_X;
            head_y_q    <= CTR_Y;
            dir_q       <= RIGHT;
            pending_q   <= RIGHT;
            cand_x_q    <= CTR_X;
            cand_y_q    <= CTR_Y;
            cand_dir_q  <= RIGHT;
            check_req_q <= 1'b0;
            shift_q     <= 1'b0;
            grow_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            dir_q       <= dir_d;
            pending_q   <= pending_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            cand_dir_q  <= cand_dir_d;
            check_req_q <= check_req_d;
            shift_q     <= shift_d;
            grow_q      <= grow_d;
            collision_q <= collision_d;
        end
    end

    assign check_req_o = check_req_q;
    assign check_x_o   = cand_x_q;
    assign check_y_o   = cand_y_q;
    assign shift_o     = shift_q;
    assign grow_o      = grow_q;
    assign head_x_o    = head_x_q;
    assign head_y_o    = head_y_q;
    assign dir_o       = dir_q;
    assign collision_o = collision_q;

endmodule
